trim_sweep_ctrl: RTL and testbench

- Sequences trim codes into the serial trim loader.
- Single mode: loads one code. Sweep mode: steps from CODE_START to CODE_END by CODE_STEP.
- Holds each code for a programmable dwell so the bandgap output can settle and be measured.
- Sits between board switches/keys and the loader; owns all loader requests; runs on CLOCK_50 with a tick-enable prescaler, no derived clocks.

---
 rtl/trim_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_trim_sweep_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_sweep_ctrl.sv
// rtl/trim_sweep_ctrl.sv - trim code sequencer for the serial trim loader
//
// Purpose: loads a single trim code or sweeps CODE_START..CODE_END by
// CODE_STEP, handing each code to the loader and holding it for a dwell
// period so the bandgap output can settle and be measured. All timing runs
// on CLOCK_50 gated by a one-cycle TICK enable from an internal prescaler.
//
// Optional build macro: TRIM_LD_TIMEOUT_EN enables a loader watchdog that
// raises the sticky ERR flag and abandons the run if the loader stalls.
//
// Ports:
//   CLOCK_50    in   system clock
//   RST         in   asynchronous active-high reset
//   START       in   raw key level, rising edge starts a run (IDLE only)
//   ABORT       in   raw key level, rising edge aborts a run
//   MODE        in   0 = single load, 1 = sweep
//   CODE_START  in   first code
//   CODE_END    in   last code of a sweep
//   CODE_STEP   in   sweep increment
//   LD_ACK      in   loader accepted the request
//   LD_DONE     in   loader finished shifting (one-cycle pulse)
//   LD_REQ      out  load request
//   LD_CODE     out  code to load
//   CUR_CODE    out  last successfully loaded code
//   TICK        out  one-cycle prescaler pulse
//   BUSY        out  run in progress
//   DONE        out  one-cycle pulse at normal run end
//   ERR         out  sticky loader-timeout flag
//   STATE       out  state encoding for debug LEDs
module trim_sweep_ctrl #(
  parameter int WIDTH         = 12,
  parameter int CLK_DIV       = 12500000,
  parameter int SETTLE_TICKS  = 3,
  parameter int DWELL_TICKS   = 8,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic [WIDTH-1:0] CODE_START,
  input  logic [WIDTH-1:0] CODE_END,
  input  logic [WIDTH-1:0] CODE_STEP,
  input  logic             LD_ACK,
  input  logic             LD_DONE,
  output logic             LD_REQ,
  output logic [WIDTH-1:0] LD_CODE,
  output logic [WIDTH-1:0] CUR_CODE,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_LD = 3'd3,
    S_DWELL   = 3'd4,
    S_NEXT    = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t           r_state;
  logic [PW-1:0]    r_presc;
  logic [2:0]       r_start_sync;
  logic [2:0]       r_abort_sync;
  logic [31:0]      r_tcnt;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_cur_code;
  logic [WIDTH-1:0] r_end;
  logic [WIDTH-1:0] r_step;
  logic             r_mode;

  logic             w_tick;
  logic             w_start_edge;
  logic             w_abort_edge;
  logic             w_settle_hit;
  logic             w_dwell_hit;
  logic [WIDTH:0]   w_next;
  logic             w_last;
  logic             w_wd_expire;

  // Free-running prescaler; TICK is the terminal count.
  assign w_tick = (r_presc == PW'(CLK_DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Bits [1:0] synchronise the raw key, bit [2] holds the previous sample
  // for rising-edge detection.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_start_sync <= '0;
      r_abort_sync <= '0;
    end else begin
      r_start_sync <= {r_start_sync[1:0], START};
      r_abort_sync <= {r_abort_sync[1:0], ABORT};
    end
  end

  assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
  assign w_abort_edge = r_abort_sync[1] & ~r_abort_sync[2];

  // A zero count exits immediately; otherwise exit on the tick that
  // completes the count.
  assign w_settle_hit = (SETTLE_TICKS == 0) ||
                        (w_tick && (r_tcnt + 32'd1 == 32'(SETTLE_TICKS)));
  assign w_dwell_hit  = (DWELL_TICKS == 0) ||
                        (w_tick && (r_tcnt + 32'd1 == 32'(DWELL_TICKS)));

  // One extra bit catches wrap-around so the sweep never restarts at 0.
  assign w_next = {1'b0, r_cur} + {1'b0, r_step};
  assign w_last = !r_mode || (r_step == '0) || w_next[WIDTH] ||
                  (w_next > {1'b0, r_end});

`ifdef TRIM_LD_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_err;
  logic        w_in_ld;

  assign w_in_ld     = (r_state == S_ISSUE) || (r_state == S_WAIT_LD);
  assign w_wd_expire = w_in_ld && ((TIMEOUT_TICKS == 0) ||
                       (w_tick && (r_wdog + 32'd1 == 32'(TIMEOUT_TICKS))));

  // ISSUE is only entered from outside the loader states, so clearing the
  // watchdog whenever we are outside them clears it on every ISSUE entry.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (!w_in_ld) begin
        r_wdog <= '0;
      end else if (w_tick) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if ((r_state == S_IDLE) && w_start_edge) begin
        r_err <= 1'b0;
      end else if (w_wd_expire && !w_abort_edge) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ERR = r_err;
`else
  localparam int unused_timeout_ticks = TIMEOUT_TICKS;
  assign w_wd_expire = 1'b0;
  assign ERR         = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_cur      <= '0;
      r_cur_code <= '0;
      r_end      <= '0;
      r_step     <= '0;
      r_mode     <= 1'b0;
    end else if (w_abort_edge && (r_state != S_IDLE)) begin
      // Abort outranks any loader handshake in the same cycle.
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else if (w_wd_expire) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_cur   <= CODE_START;
            r_end   <= CODE_END;
            r_step  <= CODE_STEP;
            r_mode  <= MODE;
            r_tcnt  <= '0;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_settle_hit) begin
            r_tcnt  <= '0;
            r_state <= S_ISSUE;
          end else if (w_tick) begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_ISSUE: begin
          // An LD_DONE coinciding with LD_ACK is not looked at here.
          if (LD_ACK) begin
            r_state <= S_WAIT_LD;
          end
        end
        S_WAIT_LD: begin
          if (LD_DONE) begin
            r_cur_code <= r_cur;
            r_tcnt     <= '0;
            r_state    <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (w_dwell_hit) begin
            r_tcnt  <= '0;
            r_state <= S_NEXT;
          end else if (w_tick) begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_cur   <= w_next[WIDTH-1:0];
            r_state <= S_ISSUE;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state register directly, so reset clears them at once.
  assign LD_REQ   = (r_state == S_ISSUE);
  assign LD_CODE  = r_cur;
  assign CUR_CODE = r_cur_code;
  assign TICK     = w_tick;
  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = (r_state == S_FINISH);
  assign STATE    = r_state;

endmodule

// File: tb/tb_trim_sweep_ctrl.sv
// tb/tb_trim_sweep_ctrl.sv - self-checking bench for trim_sweep_ctrl
module tb_trim_sweep_ctrl;

  localparam int W      = 12;
  localparam int CDIV   = 4;
  localparam int SETTLE = 2;
  localparam int DWELL  = 3;
  localparam int TMO    = 5;

  logic          CLOCK_50, RST, START, ABORT, MODE, LD_ACK, LD_DONE;
  logic [W-1:0]  CODE_START, CODE_END, CODE_STEP;
  logic          LD_REQ, TICK, BUSY, DONE, ERR;
  logic [W-1:0]  LD_CODE, CUR_CODE;
  logic [2:0]    STATE;

  trim_sweep_ctrl #(
    .WIDTH(W), .CLK_DIV(CDIV), .SETTLE_TICKS(SETTLE),
    .DWELL_TICKS(DWELL), .TIMEOUT_TICKS(TMO)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .START(START), .ABORT(ABORT),
    .MODE(MODE), .CODE_START(CODE_START), .CODE_END(CODE_END),
    .CODE_STEP(CODE_STEP), .LD_ACK(LD_ACK), .LD_DONE(LD_DONE),
    .LD_REQ(LD_REQ), .LD_CODE(LD_CODE), .CUR_CODE(CUR_CODE), .TICK(TICK),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STATE(STATE)
  );

  int n_cmp = 0;
  int n_mis = 0;

  int exp_q[$];
  int req_q[$];
  int gap_q[$];
  int t_since = 0, t_req = 0, done_cnt = 0, done_gap = 0, ld_done_cnt = 0;
  int stable_bad = 0, tick_bad = 0, cyc_n = 0, last_tick = -1;
  bit run_end = 0, prev_busy = 0, prev_req = 0;
  logic [W-1:0] prev_code = '0;

  bit ld_en = 1, ld_done_en = 1;
  int ldst = 0, ldly = 0;

  initial begin
    CLOCK_50 = 0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Loader model: ack after a random delay, then pulse LD_DONE later.
  initial begin
    LD_ACK = 0;
    LD_DONE = 0;
    forever begin
      @(negedge CLOCK_50);
      LD_ACK = 0;
      LD_DONE = 0;
      case (ldst)
        0: if (ld_en && LD_REQ) begin ldly = $urandom_range(0, 3); ldst = 1; end
        1: if (!LD_REQ) ldst = 0;
           else if (ldly == 0) begin LD_ACK = 1; ldst = 2; ldly = $urandom_range(0, 4); end
           else ldly--;
        default: if (ldly == 0) begin LD_DONE = ld_done_en; ldst = 0; end
                 else ldly--;
      endcase
    end
  end

  // Monitor: records requested codes and tick distances between events.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (RST) begin
        last_tick = -1;
        prev_busy = 0;
        prev_req = 0;
      end else begin
        cyc_n++;
        if (TICK) begin
          if (last_tick >= 0 && cyc_n - last_tick != CDIV) tick_bad++;
          last_tick = cyc_n;
        end
        if (LD_REQ && !prev_req) begin
          req_q.push_back(int'(LD_CODE));
          gap_q.push_back(t_since);
          t_req = TICK ? 1 : 0;
        end else if (BUSY && TICK) begin
          t_req++;
        end
        if (LD_REQ && prev_req && LD_CODE != prev_code) stable_bad++;
        if (DONE) begin done_cnt++; done_gap = t_since; end
        if (LD_DONE && BUSY) ld_done_cnt++;
        if (LD_DONE || (BUSY && !prev_busy)) t_since = (!LD_DONE && TICK) ? 1 : 0;
        else if (TICK) t_since++;
        if (!BUSY && prev_busy) run_end = 1;
        prev_busy = BUSY;
        prev_req = LD_REQ;
        prev_code = LD_CODE;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Reference: every start+k*step that does not exceed end (single mode or
  // zero step loads only the start code).
  function automatic void model(input bit m, input int s, input int e, input int st);
    int c;
    exp_q.delete();
    c = s;
    exp_q.push_back(c);
    if (m && st != 0) begin
      while (c + st <= e && c + st < (1 << W)) begin
        c = c + st;
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic clear_mon();
    req_q.delete();
    gap_q.delete();
    done_cnt = 0;
    ld_done_cnt = 0;
    stable_bad = 0;
    run_end = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    START = 1;
    cyc(3);
    START = 0;
  endtask

  task automatic run_test(input bit m, input int s, input int e, input int st, input string nm);
    bit seen;
    int n;
    model(m, s, e, st);
    clear_mon();
    MODE = m;
    CODE_START = W'(s);
    CODE_END = W'(e);
    CODE_STEP = W'(st);
    pulse_start();
    seen = 0;
    for (int k = 0; k < 6000 && !run_end; k++) begin
      @(negedge CLOCK_50);
      if (BUSY && !seen) begin
        // Inputs must be ignored once latched.
        seen = 1;
        MODE = 1'($urandom);
        CODE_START = W'($urandom);
        CODE_END = W'($urandom);
        CODE_STEP = W'($urandom);
      end
    end
    chk({nm, " run_ended"}, 32'(run_end), 1);
    cyc(2);
    chk({nm, " n_loads"}, req_q.size(), exp_q.size());
    n = (req_q.size() < exp_q.size()) ? req_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s code%0d", nm, i), req_q[i], exp_q[i]);
      chk($sformatf("%s gap%0d", nm, i), gap_q[i], (i == 0) ? SETTLE : DWELL);
    end
    chk({nm, " done_cnt"}, done_cnt, 1);
    chk({nm, " done_gap"}, done_gap, DWELL);
    chk({nm, " cur_code"}, 32'(CUR_CODE), exp_q[exp_q.size() - 1]);
    chk({nm, " busy"}, 32'(BUSY), 0);
    chk({nm, " state"}, 32'(STATE), 0);
    chk({nm, " err"}, 32'(ERR), 0);
    chk({nm, " ld_code_stable"}, stable_bad, 0);
  endtask

  initial begin
    int s, e, st;
    bit m;
    bit got;
    RST = 1;
    START = 0;
    ABORT = 0;
    MODE = 0;
    CODE_START = '0;
    CODE_END = '0;
    CODE_STEP = '0;
    cyc(3);
    chk("rst ld_req", 32'(LD_REQ), 0);
    chk("rst busy", 32'(BUSY), 0);
    chk("rst done", 32'(DONE), 0);
    chk("rst state", 32'(STATE), 0);
    chk("rst err", 32'(ERR), 0);
    chk("rst tick", 32'(TICK), 0);
    chk("rst cur_code", 32'(CUR_CODE), 0);
    chk("rst ld_code", 32'(LD_CODE), 0);
    RST = 0;
    cyc(4);

    run_test(0, 'h7BF, 'h123, 'h5, "single");
    run_test(1, 'h000, 'h00A, 'h3, "sweep3");
    run_test(1, 'hFFE, 'hFFF, 'h4, "overflow");
    run_test(1, 'h010, 'h005, 'h1, "start_gt_end");
    run_test(1, 'h020, 'h080, 'h0, "step0");
    run_test(1, 'h000, 'hFFF, 'hFFF, "full_range");

    for (int r = 0; r < 6; r++) begin
      m = (r == 5) ? 1'b0 : 1'b1;
      st = $urandom_range(1, 300);
      s = $urandom_range(0, (1 << W) - 1);
      e = s + $urandom_range(0, st * 10);
      if (e > (1 << W) - 1) e = (1 << W) - 1;
      run_test(m, s, e, st, $sformatf("rand%0d", r));
    end

    // Abort during the dwell of the second code.
    clear_mon();
    MODE = 1;
    CODE_START = 'h000;
    CODE_END = 'h009;
    CODE_STEP = 'h001;
    pulse_start();
    got = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge CLOCK_50);
      got = (ld_done_cnt == 2);
    end
    chk("abort reached_dwell2", 32'(got), 1);
    ABORT = 1;
    cyc(2);
    chk("abort busy_before_edge", 32'(BUSY), 1);
    cyc(1);
    chk("abort busy", 32'(BUSY), 0);
    chk("abort state", 32'(STATE), 0);
    chk("abort ld_req", 32'(LD_REQ), 0);
    ABORT = 0;
    cyc(20);
    chk("abort no_done", done_cnt, 0);
    chk("abort cur_code", 32'(CUR_CODE), 'h001);
    chk("abort n_loads", req_q.size(), 2);
    run_test(1, 'h000, 'h009, 'h001, "restart");

    // Reset while a request is outstanding.
    ld_en = 0;
    clear_mon();
    MODE = 1;
    CODE_START = 'h100;
    CODE_END = 'h200;
    CODE_STEP = 'h001;
    pulse_start();
    got = 0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge CLOCK_50);
      got = LD_REQ;
    end
    chk("rstrun reached_issue", 32'(got), 1);
    RST = 1;
    #1;
    chk("rstrun ld_req", 32'(LD_REQ), 0);
    chk("rstrun busy", 32'(BUSY), 0);
    chk("rstrun state", 32'(STATE), 0);
    START = 1;
    cyc(3);
    START = 0;
    cyc(2);
    RST = 0;
    ld_en = 1;
    cyc(10);
    chk("rstrun start_ignored", 32'(BUSY), 0);
    chk("rstrun idle", 32'(STATE), 0);

`ifdef TRIM_LD_TIMEOUT_EN
    ld_done_en = 0;
    clear_mon();
    MODE = 0;
    CODE_START = 'h123;
    pulse_start();
    for (int k = 0; k < 1000 && !run_end; k++) @(negedge CLOCK_50);
    chk("tmo run_ended", 32'(run_end), 1);
    chk("tmo err", 32'(ERR), 1);
    chk("tmo state", 32'(STATE), 0);
    chk("tmo no_done", done_cnt, 0);
    chk("tmo ticks", t_req, TMO);
    chk("tmo n_loads", req_q.size(), 1);
    cyc(20);
    chk("tmo err_sticky", 32'(ERR), 1);
    ld_done_en = 1;
    run_test(0, 'h055, 'h000, 'h000, "after_tmo");
`else
    chk("no_wdog err", 32'(ERR), 0);
`endif

    chk("tick_period", tick_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
